// File: rtl/qif_neuron_array_if.sv
// Bus between the synaptic front end / spike router and qif_neuron_array.
// master drives step requests and readback select; slave returns status and spikes.
interface qif_neuron_array_if #(
    parameter int WIDTH     = 8,
    parameter int N_NEURONS = 4
);
    localparam int unsigned IDXW = $clog2(N_NEURONS);

    logic                         start;
    logic [N_NEURONS*WIDTH-1:0]   i_syn;
    logic [IDXW-1:0]              rd_sel;
    logic                         busy;
    logic                         done;
    logic [N_NEURONS-1:0]         spike_vec;
    logic signed [WIDTH-1:0]      rd_v;

    modport master (
        output start, i_syn, rd_sel,
        input  busy, done, spike_vec, rd_v
    );

    modport slave (
        input  start, i_syn, rd_sel,
        output busy, done, spike_vec, rd_v
    );
endinterface

// File: rtl/qif_neuron_array.sv
// Time-multiplexed quadratic integrate-and-fire neuron array, one neuron updated per cycle.
// Define QIF_LEAK_EN to add the -(v>>>LEAK_SHIFT) leak term to integration.
module qif_neuron_array #(
    parameter int WIDTH      = 8,
    parameter int N_NEURONS  = 4,
    parameter int V_RESET    = -20,
    parameter int V_TH       = 50,
    parameter int SQ_SHIFT   = 3,
    parameter int IN_SHIFT   = 2,
    parameter int REFRACT    = 3,
    parameter int LEAK_SHIFT = 4
) (
    input logic              clk,
    input logic              reset,
    qif_neuron_array_if.slave bus
);
    localparam int unsigned IDXW = $clog2(N_NEURONS);
    localparam int unsigned SW   = 2 * WIDTH + 2;
    localparam int unsigned RW   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    localparam logic signed [WIDTH-1:0] VRST_W = WIDTH'(V_RESET);
    localparam logic signed [WIDTH-1:0] VTH_W  = WIDTH'(V_TH);
    localparam logic [RW-1:0]           REFR_W = RW'(REFRACT);
    localparam logic [IDXW-1:0]         LAST_W = IDXW'(N_NEURONS - 1);
    localparam logic signed [SW-1:0]    SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]    SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    if (WIDTH < 4 || N_NEURONS < 2 || SQ_SHIFT < 0 || IN_SHIFT < 0 ||
        REFRACT < 0 || LEAK_SHIFT < 0) begin : g_bad_param
        $error("qif_neuron_array: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic signed [WIDTH-1:0] v_q [N_NEURONS];
    logic signed [WIDTH-1:0] v_d [N_NEURONS];
    logic [RW-1:0]           refr_q [N_NEURONS];
    logic [RW-1:0]           refr_d [N_NEURONS];
    logic signed [WIDTH-1:0] i_cap_q [N_NEURONS];
    logic signed [WIDTH-1:0] i_cap_d [N_NEURONS];
    logic [N_NEURONS-1:0]    spike_sh_q, spike_sh_d;
    logic [N_NEURONS-1:0]    spike_vec_q, spike_vec_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic signed [WIDTH-1:0] rd_v_q, rd_v_d;

    logic signed [WIDTH-1:0] v_cur, i_cur, s_cur, v_sat;
    logic signed [SW-1:0]    sum;

    // Shared integrator: full-precision sum, then clamp to the WIDTH-bit signed range.
    always_comb begin
        v_cur = v_q[idx_q];
        i_cur = i_cap_q[idx_q];
        s_cur = v_cur >>> SQ_SHIFT;
`ifdef QIF_LEAK_EN
        sum = SW'(v_cur) + SW'(s_cur) * SW'(s_cur) + SW'(i_cur >>> IN_SHIFT)
            - SW'(v_cur >>> LEAK_SHIFT);
`else
        sum = SW'(v_cur) + SW'(s_cur) * SW'(s_cur) + SW'(i_cur >>> IN_SHIFT);
`endif
        if (sum > SAT_MAX) begin
            v_sat = SAT_MAX[WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            v_sat = SAT_MIN[WIDTH-1:0];
        end else begin
            v_sat = sum[WIDTH-1:0];
        end
    end

    // Step sequencing and per-neuron rule selection.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        v_d         = v_q;
        refr_d      = refr_q;
        i_cap_d     = i_cap_q;
        spike_sh_d  = spike_sh_q;
        spike_vec_d = spike_vec_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int k = 0; k < N_NEURONS; k++) begin
                        i_cap_d[k] = bus.i_syn[k*WIDTH +: WIDTH];
                    end
                    spike_sh_d = '0;
                    idx_d      = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (refr_q[idx_q] != '0) begin
                    v_d[idx_q]    = VRST_W;
                    refr_d[idx_q] = refr_q[idx_q] - RW'(1);
                end else if (v_q[idx_q] >= VTH_W) begin
                    spike_sh_d[idx_q] = 1'b1;
                    v_d[idx_q]        = VRST_W;
                    refr_d[idx_q]     = REFR_W;
                end else begin
                    v_d[idx_q] = v_sat;
                end
                if (idx_q == LAST_W) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                spike_vec_d = spike_sh_q;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        rd_v_d = v_q[bus.rd_sel];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_q[k]     <= VRST_W;
                refr_q[k]  <= '0;
                i_cap_q[k] <= '0;
            end
            spike_sh_q  <= '0;
            spike_vec_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_v_q      <= VRST_W;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            v_q         <= v_d;
            refr_q      <= refr_d;
            i_cap_q     <= i_cap_d;
            spike_sh_q  <= spike_sh_d;
            spike_vec_q <= spike_vec_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rd_v_q      <= rd_v_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.spike_vec = spike_vec_q;
    assign bus.rd_v      = rd_v_q;
endmodule

// File: tb/tb_qif_neuron_array.sv
// Directed bench for qif_neuron_array (default build, QIF_LEAK_EN undefined).
// Instance a uses default parameters, instance b uses V_TH=127 for the saturation case.
module tb_qif_neuron_array;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    qif_neuron_array_if #(.WIDTH(8), .N_NEURONS(4)) ia ();
    qif_neuron_array_if #(.WIDTH(8), .N_NEURONS(4)) ib ();

    qif_neuron_array #(.WIDTH(8), .N_NEURONS(4)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    qif_neuron_array #(.WIDTH(8), .N_NEURONS(4), .V_TH(127)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    typedef struct {
        bit          sel;
        bit          rst;
        logic [31:0] isyn;
        logic [1:0]  rd;
        int          exp_v;
        int          exp_spk;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input bit sel, input bit rst, input logic [31:0] isyn,
                                input logic [1:0] rd, input int ev, input int es);
        vec_t t;
        t.sel = sel; t.rst = rst; t.isyn = isyn; t.rd = rd; t.exp_v = ev; t.exp_spk = es;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One full timestep; returns rd_v of the selected neuron and spike_vec in the done cycle.
    task automatic do_step(input bit sel, input logic [31:0] isyn, input logic [1:0] rd,
                           output int v, output int spk);
        int n;
        @(negedge clk);
        if (sel) begin ib.i_syn = isyn; ib.rd_sel = rd; ib.start = 1'b1; end
        else     begin ia.i_syn = isyn; ia.rd_sel = rd; ia.start = 1'b1; end
        @(negedge clk);
        ia.start = 1'b0;
        ib.start = 1'b0;
        n = 0;
        while (!(sel ? ib.done : ia.done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("done_timeout", n, 0);
        spk = sel ? int'(ib.spike_vec) : int'(ia.spike_vec);
        v   = sel ? int'(ib.rd_v) : int'(ia.rd_v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   traj[10];
        int   v, spk, d1, d2, busy_cnt, n_done;

        traj = '{-11, -7, -6, -5, -4, -3, -2, -1, 0, 0};
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, i == 0, 32'h0, 2'd0, traj[i], 0));
        tbl.push_back(mk(0, 1, 32'h0000_007F, 2'd0,  20, 0));
        tbl.push_back(mk(0, 0, 32'h0000_007F, 2'd0,  55, 0));
        tbl.push_back(mk(0, 0, 32'h0000_007F, 2'd0, -20, 1));
        tbl.push_back(mk(0, 0, 32'h0000_007F, 2'd0, -20, 0));
        tbl.push_back(mk(0, 0, 32'h0000_007F, 2'd0, -20, 0));
        tbl.push_back(mk(0, 0, 32'h0000_007F, 2'd0, -20, 0));
        tbl.push_back(mk(0, 0, 32'h0000_007F, 2'd0,  20, 0));
        tbl.push_back(mk(1, 1, 32'h0000_7F00, 2'd1,  20, 0));
        tbl.push_back(mk(1, 0, 32'h0000_7F00, 2'd1,  55, 0));
        tbl.push_back(mk(1, 0, 32'h0000_7F00, 2'd1, 122, 0));
        tbl.push_back(mk(1, 0, 32'h0000_7F00, 2'd1, 127, 0));
        tbl.push_back(mk(1, 0, 32'h0000_7F00, 2'd1, -20, 2));

        ia.start = 1'b0; ia.i_syn = '0; ia.rd_sel = '0;
        ib.start = 1'b0; ib.i_syn = '0; ib.rd_sel = '0;

        @(negedge clk);
        chk("rst_a_busy",  int'(ia.busy), 0);
        chk("rst_a_done",  int'(ia.done), 0);
        chk("rst_a_spike", int'(ia.spike_vec), 0);
        chk("rst_a_rdv",   int'(ia.rd_v), -20);
        chk("rst_b_busy",  int'(ib.busy), 0);
        chk("rst_b_done",  int'(ib.done), 0);
        chk("rst_b_spike", int'(ib.spike_vec), 0);
        chk("rst_b_rdv",   int'(ib.rd_v), -20);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            do_step(tbl[i].sel, tbl[i].isyn, tbl[i].rd, v, spk);
            chk($sformatf("vec%0d_v", i), v, tbl[i].exp_v);
            chk($sformatf("vec%0d_spike", i), spk, tbl[i].exp_spk);
        end

        // Back-to-back steps with start held high; neuron 3 input dropped mid-step.
        do_reset();
        d1 = -1; d2 = -1; busy_cnt = 0;
        @(negedge clk);
        ia.i_syn = 32'h7F00_0000; ia.rd_sel = 2'd3; ia.start = 1'b1;
        for (int c = 0; c < 40 && d2 < 0; c++) begin
            @(negedge clk);
            if (c == 2) ia.i_syn = '0;
            if (ia.done) begin
                if (d1 < 0) begin
                    d1 = c;
                    chk("cont_v3_step1", int'(ia.rd_v), 20);
                end else begin
                    d2 = c;
                    chk("cont_v3_step2", int'(ia.rd_v), 24);
                end
            end
            if (d1 >= 0 && d2 < 0 && ia.busy) busy_cnt++;
        end
        ia.start = 1'b0;
        chk("cont_period", d2 - d1, 6);
        chk("cont_busy_cycles", busy_cnt, 5);

        // Reset in the middle of a step, after a spike has been published.
        do_reset();
        do_step(0, 32'h0000_007F, 2'd0, v, spk);
        do_step(0, 32'h0000_007F, 2'd0, v, spk);
        do_step(0, 32'h0000_007F, 2'd0, v, spk);
        chk("abort_pre_spike", spk, 1);
        @(negedge clk);
        ia.i_syn = 32'h0000_007F; ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", int'(ia.busy), 1);
        reset = 1'b1;
        #1;
        chk("abort_busy",  int'(ia.busy), 0);
        chk("abort_done",  int'(ia.done), 0);
        chk("abort_spike", int'(ia.spike_vec), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ia.done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        for (int k = 0; k < 4; k++) begin
            ia.rd_sel = 2'(k);
            @(negedge clk);
            chk($sformatf("abort_rdv%0d", k), int'(ia.rd_v), -20);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
